// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit 7-segment scanner.
// Segment encodings are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 15 first, entry 0 last
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the display scanner.
// Flags blanking, slot start and the digit 3 -> 0 wrap.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx_o,
  output logic             in_blank_o,
  output logic             slot_start_o,
  output logic             frame_wrap_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             term;

  assign term = (cnt_q == LAST);

  // Advance the slot counter; step the digit at terminal count
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (term) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign in_blank_o   = (cnt_q < BLANK_C);
  assign slot_start_o = (cnt_q == '0);
  assign frame_wrap_o = term && (idx_q == IDX_LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display.
// Frame-buffered inputs, blanking between digits, registered pins.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  logic [IDX_W-1:0] idx;
  logic             in_blank;
  logic             slot_start;
  logic             frame_wrap;
  logic             capture;

  logic [15:0]           val_sh_q;
  logic [NUM_DIGITS-1:0] en_sh_q, dp_sh_q;

  logic [15:0]           val_eff;
  logic [NUM_DIGITS-1:0] en_eff, dp_eff;
  logic [3:0]            nib;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q;

  seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .idx_o        (idx),
    .in_blank_o   (in_blank),
    .slot_start_o (slot_start),
    .frame_wrap_o (frame_wrap)
  );

  assign capture = slot_start && (idx == '0);

  // On the capture cycle use the live inputs so digit 0 of the
  // new frame is already correct even with no blanking window.
  assign val_eff = capture ? value    : val_sh_q;
  assign en_eff  = capture ? digit_en : en_sh_q;
  assign dp_eff  = capture ? dp_in    : dp_sh_q;
  assign nib     = val_eff[{idx, 2'b00} +: 4];

  // Frame shadow registers, loaded once per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      val_sh_q <= '0;
      en_sh_q  <= '0;
      dp_sh_q  <= '0;
    end else if (capture) begin
      val_sh_q <= value;
      en_sh_q  <= digit_en;
      dp_sh_q  <= dp_in;
    end
  end

  // Digit/segment mux for the current slot state
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_blank) begin
      if (en_eff[idx]) begin
        an_d = ~(NUM_DIGITS'(1) << idx);
      end
      seg_d = hex2seg(nib);
      dp_d  = ~dp_eff[idx];
    end
  end

  // Output registers driving the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= frame_wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner.
// REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

  localparam int RD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h12AF;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [12:0] exp_q[$];
  logic        started = 1'b0;
  logic        phase4 = 1'b0;

  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_vsh = '0;
  logic [3:0]  m_esh = '0;
  logic [3:0]  m_dsh = '0;

  int cyc = 0;
  int last_fd = -1;

  seven_seg_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] tb_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Expected {an, seg, dp, frame_done} one cycle after the given state
  function automatic logic [12:0] exp_out(
    input logic rst, input int c, input int ix,
    input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    logic [3:0] a;
    logic fd;
    if (rst) return {4'hF, 7'h7F, 1'b1, 1'b0};
    fd = (c == RD - 1) && (ix == 3);
    if (c < BL) return {4'hF, 7'h7F, 1'b1, fd};
    a = 4'hF;
    if (e[ix]) begin
      case (ix)
        0: a = 4'hE;
        1: a = 4'hD;
        2: a = 4'hB;
        default: a = 4'h7;
      endcase
    end
    return {a, tb_dec(v[ix*4 +: 4]), ~d[ix], fd};
  endfunction

  // Reference state; pushes one expectation per clock
  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      exp_q.push_back(exp_out(1'b1, 0, 0, '0, '0, '0));
      m_cnt <= 0;
      m_idx <= 0;
      m_vsh <= '0;
      m_esh <= '0;
      m_dsh <= '0;
    end else begin
      if (m_cnt == 0 && m_idx == 0) begin
        exp_q.push_back(exp_out(1'b0, m_cnt, m_idx, value, digit_en, dp_in));
        m_vsh <= value;
        m_esh <= digit_en;
        m_dsh <= dp_in;
      end else begin
        exp_q.push_back(exp_out(1'b0, m_cnt, m_idx, m_vsh, m_esh, m_dsh));
      end
      if (m_cnt == RD - 1) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Monitor: pop and compare on the falling edge
  always @(negedge clk) begin
    if (started) begin
      logic [12:0] x;
      cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL queue_empty at cycle %0d", cyc);
      end else begin
        x = exp_q.pop_front();
        checks++;
        if (an !== x[12:9]) begin
          failures++;
          $display("FAIL an cyc=%0d got=%h exp=%h", cyc, an, x[12:9]);
        end
        checks++;
        if (seg !== x[8:2]) begin
          failures++;
          $display("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, x[8:2]);
        end
        checks++;
        if (dp !== x[1]) begin
          failures++;
          $display("FAIL dp cyc=%0d got=%b exp=%b", cyc, dp, x[1]);
        end
        checks++;
        if (frame_done !== x[0]) begin
          failures++;
          $display("FAIL frame_done cyc=%0d got=%b exp=%b",
                   cyc, frame_done, x[0]);
        end
      end
      if (reset) begin
        last_fd = -1;
      end else if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (cyc - last_fd != 4 * RD) begin
            failures++;
            $display("FAIL fd_period got=%0d exp=%0d",
                     cyc - last_fd, 4 * RD);
          end
        end
        last_fd = cyc;
      end
      if (phase4) begin
        checks++;
        if (an[3:2] !== 2'b11) begin
          failures++;
          $display("FAIL an_hi_dark cyc=%0d got=%b exp=11", cyc, an[3:2]);
        end
      end
    end
  end

  task automatic wait_state(input int ix, input int c, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (m_idx == ix && m_cnt == c) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s got=none exp=idx%0d_cnt%0d", nm, ix, c);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (64) @(posedge clk);
    #1;

    wait_state(1, 3, "mid_digit1");
    value = 16'h0000;
    repeat (70) @(posedge clk);
    #1;

    digit_en = 4'b0011;
    dp_in    = 4'b0100;
    repeat (40) @(posedge clk);
    #1;
    phase4 = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    phase4 = 1'b0;

    digit_en = 4'hF;
    dp_in    = 4'b0001;
    wait_state(2, 4, "digit2_show");
    reset = 1'b1;
    value = 16'h3456;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (70) @(posedge clk);
    #1;

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
